// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JAL    = 2'b10,
    PC_JALR   = 2'b11
  } pcsrc_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    HALT = 3'd4
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response channel: req/ready grant, then rvalid data.
interface fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  ready;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, addr, input ready, rvalid, rdata);
  modport slave  (input req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/next_pc_sel.sv
// Combinational next-PC mux; flags targets that are not word aligned.
module next_pc_sel
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [1:0]            PCsrc,
  input  logic [ADDR_WIDTH-1:0] ImmOp,
  input  logic [ADDR_WIDTH-1:0] alu_target,
  output logic [ADDR_WIDTH-1:0] next_pc,
  output logic                  misaligned
);

  always_comb begin
    next_pc = pc + ADDR_WIDTH'(4);
    case (pcsrc_e'(PCsrc))
      PC_PLUS4:          next_pc = pc + ADDR_WIDTH'(4);
      PC_BRANCH, PC_JAL: next_pc = pc + ImmOp;
      PC_JALR:           next_pc = alu_target & ~ADDR_WIDTH'(1);
      default:           next_pc = pc + ADDR_WIDTH'(4);
    endcase
    misaligned = |next_pc[1:0];
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, single-outstanding imem request FSM, instruction register.
// FETCH_MISALIGN_TRAP_EN: misaligned next PC sets sticky fetch_fault and halts.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            PCsrc,
  input  logic [ADDR_WIDTH-1:0] ImmOp,
  input  logic [ADDR_WIDTH-1:0] alu_target,
  input  logic                  instr_ack,
  fetch_if.master               imem,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic                  fetch_fault
);

  fetch_state_e          state, state_nxt;
  logic                  ld_instr, adv_pc;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic                  misaligned;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic                  trap;
`endif

  next_pc_sel #(.ADDR_WIDTH(ADDR_WIDTH)) u_next_pc_sel (
    .pc         (pc),
    .PCsrc      (PCsrc),
    .ImmOp      (ImmOp),
    .alu_target (alu_target),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_instr  = 1'b0;
    adv_pc    = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    trap      = 1'b0;
`endif
    case (state)
      IDLE: state_nxt = REQ;
      REQ:  if (imem.ready) state_nxt = WAIT;
      WAIT: if (imem.rvalid) begin
        ld_instr  = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: if (instr_ack) begin
`ifdef FETCH_MISALIGN_TRAP_EN
        if (misaligned) begin
          trap      = 1'b1;
          state_nxt = HALT;
        end else begin
          adv_pc    = 1'b1;
          state_nxt = REQ;
        end
`else
        adv_pc    = 1'b1;
        state_nxt = REQ;
`endif
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      HALT: state_nxt = HALT;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign imem.req  = (state == REQ);
  assign imem.addr = pc;
  assign pc_plus4  = pc + ADDR_WIDTH'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr       <= DATA_WIDTH'(NOP_INSTR);
      instr_valid <= 1'b0;
    end else begin
      if (ld_instr) begin
        instr       <= imem.rdata;
        instr_valid <= 1'b1;
      end
      if (adv_pc) begin
`ifdef FETCH_MISALIGN_TRAP_EN
        pc <= next_pc;
`else
        // Low bits are dropped rather than trapped when the trap is not built.
        pc <= misaligned ? {next_pc[ADDR_WIDTH-1:2], 2'b00} : next_pc;
`endif
        instr_valid <= 1'b0;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      if (trap) instr_valid <= 1'b0;
`endif
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    fetch_fault <= 1'b0;
    else if (trap) fetch_fault <= 1'b1;
  end
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; drives the imem channel by hand.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  PCsrc = 2'b00;
  logic [31:0] ImmOp = '0;
  logic [31:0] alu_target = '0;
  logic        instr_ack = 1'b0;
  logic [31:0] instr, pc, pc_plus4;
  logic        instr_valid, fetch_fault;

  int n_cmp = 0;
  int n_err = 0;

  fetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) imem ();

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .PCsrc       (PCsrc),
    .ImmOp       (ImmOp),
    .alu_target  (alu_target),
    .instr_ack   (instr_ack),
    .imem        (imem),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: grant in the REQ cycle, data one cycle later.
  task automatic do_fetch(input logic [31:0] data);
    imem.ready = 1'b1;
    tick();
    imem.ready  = 1'b0;
    imem.rvalid = 1'b1;
    imem.rdata  = data;
    tick();
    imem.rvalid = 1'b0;
  endtask

  task automatic do_ack(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] tgt);
    instr_ack  = 1'b1;
    PCsrc      = src;
    ImmOp      = imm;
    alu_target = tgt;
    tick();
    instr_ack  = 1'b0;
    PCsrc      = 2'b00;
  endtask

  task automatic test_reset();
    imem.ready = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;
    rst_n = 1'b0;
    repeat (2) tick();
    n_cmp++; if (imem.req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", imem.req); end
    n_cmp++; if (pc !== 32'hBFC0_0000) begin n_err++; $display("FAIL rst_pc: got %h want bfc00000", pc); end
    n_cmp++; if (instr !== 32'h0000_0013) begin n_err++; $display("FAIL rst_instr: got %h want 00000013", instr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    n_cmp++; if (fetch_fault !== 1'b0) begin n_err++; $display("FAIL rst_fault: got %b want 0", fetch_fault); end
    n_cmp++; if (pc_plus4 !== 32'hBFC0_0004) begin n_err++; $display("FAIL rst_pc4: got %h want bfc00004", pc_plus4); end
    rst_n = 1'b1;
    imem.ready = 1'b1;
    tick();  // cycle 1
    n_cmp++; if (imem.req !== 1'b1 || imem.addr !== 32'hBFC0_0000) begin
      n_err++; $display("FAIL first_req: got req=%b addr=%h want 1 bfc00000", imem.req, imem.addr); end
    tick();  // cycle 2: granted, waiting
    imem.ready = 1'b0;
    imem.rvalid = 1'b1; imem.rdata = 32'h1111_0001;
    n_cmp++; if (imem.req !== 1'b0 || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL wait_state: got req=%b valid=%b want 0 0", imem.req, instr_valid); end
    tick();  // cycle 3
    imem.rvalid = 1'b0;
    n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'h1111_0001) begin
      n_err++; $display("FAIL first_instr: got valid=%b instr=%h want 1 11110001", instr_valid, instr); end
  endtask

  task automatic test_hold();
    bit bad = 0;
    imem.ready  = 1'b1;           // ignored outside REQ
    imem.rvalid = 1'b1;           // ignored outside WAIT
    imem.rdata  = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (instr !== 32'h1111_0001 || pc !== 32'hBFC0_0000 || imem.req !== 1'b0 || instr_valid !== 1'b1) begin
        n_err++;
        $display("FAIL hold_%0d: got instr=%h pc=%h req=%b valid=%b want 11110001 bfc00000 0 1",
                 i, instr, pc, imem.req, instr_valid);
      end
    end
    imem.ready = 1'b0; imem.rvalid = 1'b0;
    do_ack(2'b00, 32'h0, 32'h0);
    n_cmp++; if (imem.req !== 1'b1 || imem.addr !== 32'hBFC0_0004 || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL ack_plus4: got req=%b addr=%h valid=%b want 1 bfc00004 0", imem.req, imem.addr, instr_valid); end
  endtask

  task automatic test_branch_jal();
    // step to bfc00010 with sequential fetches
    for (int i = 0; i < 3; i++) begin
      do_fetch(32'h2000_0000 + i);
      do_ack(2'b00, 32'h0, 32'h0);
    end
    n_cmp++; if (imem.addr !== 32'hBFC0_0010) begin n_err++; $display("FAIL seq_addr: got %h want bfc00010", imem.addr); end
    do_fetch(32'h3000_0001);
    n_cmp++; if (instr !== 32'h3000_0001 || pc !== 32'hBFC0_0010) begin
      n_err++; $display("FAIL pre_branch: got instr=%h pc=%h want 30000001 bfc00010", instr, pc); end
    do_ack(2'b01, 32'hFFFF_FFF8, 32'h0);
    n_cmp++; if (imem.req !== 1'b1 || imem.addr !== 32'hBFC0_0008) begin
      n_err++; $display("FAIL branch: got req=%b addr=%h want 1 bfc00008", imem.req, imem.addr); end
    for (int i = 0; i < 2; i++) begin
      do_fetch(32'h4000_0000 + i);
      do_ack(2'b00, 32'h0, 32'h0);
    end
    do_fetch(32'h5000_0001);
    do_ack(2'b10, 32'h0000_0100, 32'h0);
    n_cmp++; if (imem.addr !== 32'hBFC0_0110) begin n_err++; $display("FAIL jal: got %h want bfc00110", imem.addr); end
  endtask

  task automatic test_delayed_ready();
    bit bad = 0;
    imem.rvalid = 1'b1; imem.rdata = 32'hBAD0_0001;  // early response, must be ignored
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (imem.req !== 1'b1 || imem.addr !== 32'hBFC0_0110 || instr_valid !== 1'b0) begin
        n_err++;
        $display("FAIL stall_%0d: got req=%b addr=%h valid=%b want 1 bfc00110 0", i, imem.req, imem.addr, instr_valid);
      end
    end
    imem.ready = 1'b1;  // grant together with rvalid: only the grant counts
    tick();
    imem.ready = 1'b0; imem.rvalid = 1'b0;
    tick();
    n_cmp++; if (instr_valid !== 1'b0 || imem.req !== 1'b0) begin
      n_err++; $display("FAIL early_rvalid: got valid=%b req=%b want 0 0", instr_valid, imem.req); end
    imem.rvalid = 1'b1; imem.rdata = 32'h600D_0001;
    tick();
    imem.rvalid = 1'b0;
    n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'h600D_0001) begin
      n_err++; $display("FAIL post_grant: got valid=%b instr=%h want 1 600d0001", instr_valid, instr); end
  endtask

  task automatic test_wrap();
    do_ack(2'b11, 32'h0, 32'hFFFF_FFFC);
    n_cmp++; if (imem.addr !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
      n_err++; $display("FAIL wrap_setup: got addr=%h pc4=%h want fffffffc 00000000", imem.addr, pc_plus4); end
    do_fetch(32'h7000_0001);
    do_ack(2'b00, 32'h0, 32'h0);
    n_cmp++; if (imem.addr !== 32'h0 || fetch_fault !== 1'b0) begin
      n_err++; $display("FAIL wrap: got addr=%h fault=%b want 00000000 0", imem.addr, fetch_fault); end
  endtask

  task automatic test_jalr();
    do_fetch(32'h8000_0001);
    do_ack(2'b11, 32'h0, 32'h0000_1235);
    n_cmp++; if (imem.addr !== 32'h0000_1234 || pc_plus4 !== 32'h0000_1238) begin
      n_err++; $display("FAIL jalr: got addr=%h pc4=%h want 00001234 00001238", imem.addr, pc_plus4); end
    do_fetch(32'h8000_0002);
    do_ack(2'b11, 32'h0, 32'h0000_1236);
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (fetch_fault !== 1'b1 || imem.req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0000_1234) begin
        n_err++;
        $display("FAIL halt_%0d: got fault=%b req=%b valid=%b pc=%h want 1 0 0 00001234",
                 i, fetch_fault, imem.req, instr_valid, pc);
      end
      imem.ready = 1'b1;
      tick();
    end
    imem.ready = 1'b0;
`else
    n_cmp++; if (imem.addr !== 32'h0000_1234 || fetch_fault !== 1'b0) begin
      n_err++; $display("FAIL jalr_force: got addr=%h fault=%b want 00001234 0", imem.addr, fetch_fault); end
    do_fetch(32'h8000_0003);
    do_ack(2'b01, 32'h0000_0006, 32'h0);
    n_cmp++; if (imem.addr !== 32'h0000_1238 || fetch_fault !== 1'b0) begin
      n_err++; $display("FAIL branch_force: got addr=%h fault=%b want 00001238 0", imem.addr, fetch_fault); end
`endif
  endtask

  task automatic test_reset_mid_wait();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();          // REQ
    imem.ready = 1'b1;
    tick();          // WAIT
    imem.ready = 1'b0;
    do_ack(2'b00, 32'h0, 32'h0);  // ignored outside HOLD
    n_cmp++; if (imem.req !== 1'b0 || pc !== 32'hBFC0_0000 || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL in_wait: got req=%b pc=%h valid=%b want 0 bfc00000 0", imem.req, pc, instr_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (imem.req !== 1'b0 || pc !== 32'hBFC0_0000 || instr !== 32'h13 || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL async_rst: got req=%b pc=%h instr=%h valid=%b want 0 bfc00000 00000013 0",
                        imem.req, pc, instr, instr_valid); end
    imem.rvalid = 1'b1; imem.rdata = 32'hBAD0_0002;  // lost response
    tick();
    imem.rvalid = 1'b0;
    rst_n = 1'b1;
    tick();
    n_cmp++; if (imem.req !== 1'b1 || imem.addr !== 32'hBFC0_0000 || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL restart: got req=%b addr=%h valid=%b want 1 bfc00000 0", imem.req, imem.addr, instr_valid); end
    do_fetch(32'h9000_0001);
    n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'h9000_0001) begin
      n_err++; $display("FAIL restart_instr: got valid=%b instr=%h want 1 90000001", instr_valid, instr); end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_branch_jal();
    test_delayed_ready();
    test_wrap();
    test_jalr();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
